// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM: Moore-style state machine decoding datapath
// strobes and selects from the current state plus opcode/funct fields and ALU flags.
module mc_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero_flag,
  input  logic       comp_flag,
  output logic       PCWrite,
  output logic       AddrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       WDSrc,
  output logic       MemWrite,
  output logic [1:0] SrcA,
  output logic [1:0] SrcB,
  output logic [1:0] ResSrc,
  output logic [1:0] DataSrc,
  output logic [3:0] ALUControll,
  output logic [2:0] ImmSrc,
  output logic [1:0] memSize,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6,  S_EXECI = 4'd7,   S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10,    S_JALR = 4'd11,
                         S_LUI = 4'd12,   S_AUIPC = 4'd13,  S_TRAP = 4'd14;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R = 7'b0110011,    OP_I = 7'b0010011,
                         OP_BR = 7'b1100011,   OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_illegal;
  logic [3:0] w_alu_dec;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  // Sticky flag, raised on entry to TRAP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_illegal <= 1'b0;
    else if (w_next == S_TRAP) r_illegal <= 1'b1;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_BR:             w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR, S_EXECI: w_next = S_ALUWB;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_FETCH;
    endcase
  end

  // ALU operation for R/I-type execute; sub only exists in R-type
  always_comb begin
    w_alu_dec = ALU_ADD;
    case (funct3)
      3'b000: w_alu_dec = (r_state == S_EXECR && funct7) ? ALU_SUB : ALU_ADD;
      3'b001: w_alu_dec = ALU_SLL;
      3'b010: w_alu_dec = ALU_SLT;
      3'b011: w_alu_dec = ALU_SLTU;
      3'b100: w_alu_dec = ALU_XOR;
      3'b101: w_alu_dec = funct7 ? ALU_SRA : ALU_SRL;
      3'b110: w_alu_dec = ALU_OR;
      default: w_alu_dec = ALU_AND;
    endcase
  end

  // Output decode; write strobes are forced low while reset is held
  always_comb begin
    PCWrite = 1'b0; AddrSrc = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0;
    WDSrc = 1'b0; MemWrite = 1'b0; SrcA = 2'd0; SrcB = 2'd0; ResSrc = 2'd0;
    DataSrc = 2'd0; ALUControll = ALU_ADD; ImmSrc = IMM_I; memSize = 2'd0;
    case (r_state)
      S_FETCH: begin
        IRWrite = 1'b1; SrcB = 2'd2; ResSrc = 2'd2; PCWrite = 1'b1;
      end
      S_DECODE: begin
        SrcA = 2'd1; SrcB = 2'd1; ImmSrc = IMM_B;
      end
      S_MEMADR: begin
        SrcA = 2'd2; SrcB = 2'd1; ImmSrc = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        AddrSrc = 1'b1; memSize = funct3[1:0];
      end
      S_MEMWB: begin
        ResSrc = 2'd1; RegWrite = 1'b1;
        case (funct3)
          3'b000:  DataSrc = 2'd1;
          3'b001:  DataSrc = 2'd2;
          default: DataSrc = 2'd0;
        endcase
      end
      S_MEMWRITE: begin
        AddrSrc = 1'b1; MemWrite = 1'b1; memSize = funct3[1:0];
      end
      S_EXECR: begin
        SrcA = 2'd2; ALUControll = w_alu_dec;
      end
      S_EXECI: begin
        SrcA = 2'd2; SrcB = 2'd1; ImmSrc = IMM_I; ALUControll = w_alu_dec;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        SrcA = 2'd2;
        case (funct3)
          3'b000: begin ALUControll = ALU_SUB;  PCWrite = zero_flag;  end
          3'b001: begin ALUControll = ALU_SUB;  PCWrite = !zero_flag; end
          3'b100: begin ALUControll = ALU_SLT;  PCWrite = comp_flag;  end
          3'b101: begin ALUControll = ALU_SLT;  PCWrite = !comp_flag; end
          3'b110: begin ALUControll = ALU_SLTU; PCWrite = comp_flag;  end
          3'b111: begin ALUControll = ALU_SLTU; PCWrite = !comp_flag; end
          default: PCWrite = 1'b0;
        endcase
      end
      S_JAL, S_JALR: begin
        SrcA = (r_state == S_JAL) ? 2'd1 : 2'd2; SrcB = 2'd1;
        ImmSrc = (r_state == S_JAL) ? IMM_J : IMM_I;
        ResSrc = 2'd2; PCWrite = 1'b1; RegWrite = 1'b1; WDSrc = 1'b1;
      end
      S_LUI, S_AUIPC: begin
        SrcA = (r_state == S_LUI) ? 2'd3 : 2'd1; SrcB = 2'd1; ImmSrc = IMM_U;
        ResSrc = 2'd2; RegWrite = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    end
  end

  assign illegal = r_illegal;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its
// states and checks strobes/selects against hand-derived values.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, zero_flag, comp_flag;

  logic       PCWrite, AddrSrc, IRWrite, RegWrite, WDSrc, MemWrite, illegal;
  logic [1:0] SrcA, SrcB, ResSrc, DataSrc, memSize;
  logic [3:0] ALUControll, state;
  logic [2:0] ImmSrc;

  logic       n_PCWrite, n_AddrSrc, n_IRWrite, n_RegWrite, n_WDSrc, n_MemWrite, n_illegal;
  logic [1:0] n_SrcA, n_SrcB, n_ResSrc, n_DataSrc, n_memSize;
  logic [3:0] n_ALUControll, n_state;
  logic [2:0] n_ImmSrc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero_flag(zero_flag), .comp_flag(comp_flag),
    .PCWrite(PCWrite), .AddrSrc(AddrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .WDSrc(WDSrc), .MemWrite(MemWrite), .SrcA(SrcA), .SrcB(SrcB), .ResSrc(ResSrc),
    .DataSrc(DataSrc), .ALUControll(ALUControll), .ImmSrc(ImmSrc),
    .memSize(memSize), .illegal(illegal), .state(state)
  );

  mc_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero_flag(zero_flag), .comp_flag(comp_flag),
    .PCWrite(n_PCWrite), .AddrSrc(n_AddrSrc), .IRWrite(n_IRWrite), .RegWrite(n_RegWrite),
    .WDSrc(n_WDSrc), .MemWrite(n_MemWrite), .SrcA(n_SrcA), .SrcB(n_SrcB), .ResSrc(n_ResSrc),
    .DataSrc(n_DataSrc), .ALUControll(n_ALUControll), .ImmSrc(n_ImmSrc),
    .memSize(n_memSize), .illegal(n_illegal), .state(n_state)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 1'b0; zero_flag = 1'b0; comp_flag = 1'b0;
    tick(); tick();
    n_tests++;
    if ({state, PCWrite, IRWrite, RegWrite, MemWrite, illegal} !== {4'd0, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_hold state=%0d strobes=%b%b%b%b illegal=%b exp state=0 strobes=0000 illegal=0",
               state, PCWrite, IRWrite, RegWrite, MemWrite, illegal);
    end
    rst = 1'b1; #1;
    n_tests++;
    if ({state, PCWrite, IRWrite, SrcA, SrcB, ResSrc, ALUControll, AddrSrc} !==
        {4'd0, 1'b1, 1'b1, 2'd0, 2'd2, 2'd2, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_outputs state=%0d PCW=%b IRW=%b SrcA=%0d SrcB=%0d ResSrc=%0d ALU=%0d exp 0 1 1 0 2 2 0",
               state, PCWrite, IRWrite, SrcA, SrcB, ResSrc, ALUControll);
    end
  endtask

  task automatic test_rtype_sub();
    op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b1;
    tick();
    n_tests++;
    if ({state, SrcA, SrcB, ImmSrc, ALUControll, PCWrite, IRWrite} !== {4'd1, 2'd1, 2'd1, 3'd2, 4'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL decode state=%0d SrcA=%0d SrcB=%0d ImmSrc=%0d ALU=%0d exp 1 1 1 2 0", state, SrcA, SrcB, ImmSrc, ALUControll);
    end
    tick();
    n_tests++;
    if ({state, SrcA, SrcB, ALUControll, RegWrite} !== {4'd6, 2'd2, 2'd0, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL execr_sub state=%0d SrcA=%0d SrcB=%0d ALU=%0d exp 6 2 0 1", state, SrcA, SrcB, ALUControll);
    end
    tick();
    n_tests++;
    if ({state, RegWrite, ResSrc} !== {4'd8, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL aluwb state=%0d RegWrite=%b ResSrc=%0d exp 8 1 0", state, RegWrite, ResSrc);
    end
    tick();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL rtype_return state=%0d exp 0", state);
    end
  endtask

  task automatic test_load_lb();
    op = 7'b0000011; funct3 = 3'b000; funct7 = 1'b0;
    tick(); tick();
    n_tests++;
    if ({state, SrcA, SrcB, ImmSrc} !== {4'd2, 2'd2, 2'd1, 3'd0}) begin
      n_fail++;
      $display("FAIL load_memadr state=%0d SrcA=%0d SrcB=%0d ImmSrc=%0d exp 2 2 1 0", state, SrcA, SrcB, ImmSrc);
    end
    tick();
    n_tests++;
    if ({state, AddrSrc, ResSrc, memSize, MemWrite} !== {4'd3, 1'b1, 2'd0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL memread state=%0d AddrSrc=%b ResSrc=%0d memSize=%0d exp 3 1 0 0", state, AddrSrc, ResSrc, memSize);
    end
    tick();
    n_tests++;
    if ({state, DataSrc, RegWrite, ResSrc} !== {4'd4, 2'd1, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL memwb_lb state=%0d DataSrc=%0d RegWrite=%b ResSrc=%0d exp 4 1 1 1", state, DataSrc, RegWrite, ResSrc);
    end
    tick();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL load_latency state=%0d after 5 cycles exp 0", state);
    end
  endtask

  task automatic test_store_sw();
    op = 7'b0100011; funct3 = 3'b010;
    tick(); tick();
    n_tests++;
    if ({state, ImmSrc} !== {4'd2, 3'd1}) begin
      n_fail++;
      $display("FAIL store_memadr state=%0d ImmSrc=%0d exp 2 1", state, ImmSrc);
    end
    tick();
    n_tests++;
    if ({state, MemWrite, AddrSrc, memSize, RegWrite} !== {4'd5, 1'b1, 1'b1, 2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL memwrite state=%0d MemWrite=%b AddrSrc=%b memSize=%0d exp 5 1 1 2", state, MemWrite, AddrSrc, memSize);
    end
    tick();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL store_latency state=%0d exp 0", state);
    end
  endtask

  task automatic test_branch();
    op = 7'b1100011; funct3 = 3'b001; zero_flag = 1'b0;
    tick(); tick();
    n_tests++;
    if ({state, PCWrite, ResSrc, ALUControll, SrcA, SrcB} !== {4'd9, 1'b1, 2'd0, 4'd1, 2'd2, 2'd0}) begin
      n_fail++;
      $display("FAIL bne_taken state=%0d PCWrite=%b ResSrc=%0d ALU=%0d exp 9 1 0 1", state, PCWrite, ResSrc, ALUControll);
    end
    zero_flag = 1'b1; #1;
    n_tests++;
    if (PCWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL bne_not_taken PCWrite=%b exp 0", PCWrite);
    end
    funct3 = 3'b101; comp_flag = 1'b1; #1;
    n_tests++;
    if ({PCWrite, ALUControll} !== {1'b0, 4'd5}) begin
      n_fail++;
      $display("FAIL bge_comp1 PCWrite=%b ALU=%0d exp 0 5", PCWrite, ALUControll);
    end
    funct3 = 3'b110; #1;
    n_tests++;
    if ({PCWrite, ALUControll} !== {1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL bltu_comp1 PCWrite=%b ALU=%0d exp 1 6", PCWrite, ALUControll);
    end
    funct3 = 3'b010; #1;
    n_tests++;
    if (PCWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_f3_010 PCWrite=%b exp 0", PCWrite);
    end
    tick();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL branch_latency state=%0d exp 0", state);
    end
    zero_flag = 1'b0; comp_flag = 1'b0;
  endtask

  task automatic test_jal();
    op = 7'b1101111; funct3 = 3'b000;
    tick(); tick();
    n_tests++;
    if ({state, PCWrite, RegWrite, WDSrc, SrcA, SrcB, ImmSrc, ResSrc} !==
        {4'd10, 3'b111, 2'd1, 2'd1, 3'd3, 2'd2}) begin
      n_fail++;
      $display("FAIL jal state=%0d PCW=%b RW=%b WD=%b SrcA=%0d SrcB=%0d ImmSrc=%0d ResSrc=%0d exp 10 1 1 1 1 1 3 2",
               state, PCWrite, RegWrite, WDSrc, SrcA, SrcB, ImmSrc, ResSrc);
    end
    tick();
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL jal_return state=%0d exp 0", state);
    end
  endtask

  task automatic test_execi_lui();
    op = 7'b0010011; funct3 = 3'b101; funct7 = 1'b1;
    tick(); tick();
    n_tests++;
    if ({state, SrcA, SrcB, ImmSrc, ALUControll} !== {4'd7, 2'd2, 2'd1, 3'd0, 4'd9}) begin
      n_fail++;
      $display("FAIL execi_srai state=%0d SrcA=%0d SrcB=%0d ImmSrc=%0d ALU=%0d exp 7 2 1 0 9", state, SrcA, SrcB, ImmSrc, ALUControll);
    end
    funct3 = 3'b000; #1;
    n_tests++;
    if (ALUControll !== 4'd0) begin
      n_fail++;
      $display("FAIL execi_addi_f7 ALU=%0d exp 0", ALUControll);
    end
    tick(); tick();
    op = 7'b0110111; funct7 = 1'b0;
    tick(); tick();
    n_tests++;
    if ({state, SrcA, SrcB, ImmSrc, ResSrc, RegWrite, PCWrite} !== {4'd12, 2'd3, 2'd1, 3'd4, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL lui state=%0d SrcA=%0d SrcB=%0d ImmSrc=%0d ResSrc=%0d RW=%b exp 12 3 1 4 2 1", state, SrcA, SrcB, ImmSrc, ResSrc, RegWrite);
    end
    tick();
  endtask

  task automatic test_illegal();
    op = 7'b1111111;
    tick(); tick();
    n_tests++;
    if ({state, illegal, n_state, n_illegal} !== {4'd14, 1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_entry state=%0d illegal=%b nt_state=%0d nt_illegal=%b exp 14 1 0 0", state, illegal, n_state, n_illegal);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if ({state, illegal, PCWrite, IRWrite, RegWrite, MemWrite, AddrSrc, WDSrc} !== {4'd14, 1'b1, 6'b0}) begin
        n_fail++;
        $display("FAIL trap_hold cyc=%0d state=%0d illegal=%b strobes=%b%b%b%b exp 14 1 0000",
                 i, state, illegal, PCWrite, IRWrite, RegWrite, MemWrite);
      end
    end
    rst = 1'b0; #1;
    n_tests++;
    if ({state, illegal} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_clears_illegal state=%0d illegal=%b exp 0 0", state, illegal);
    end
    @(posedge clk); #1; rst = 1'b1; op = 7'd0;
  endtask

  task automatic test_reset_mid_store();
    op = 7'b0100011; funct3 = 3'b001;
    tick(); tick(); tick();
    n_tests++;
    if ({state, MemWrite, memSize} !== {4'd5, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL sh_memwrite state=%0d MemWrite=%b memSize=%0d exp 5 1 1", state, MemWrite, memSize);
    end
    #2; rst = 1'b0; #1;
    n_tests++;
    if ({state, MemWrite, PCWrite, IRWrite} !== {4'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL async_reset state=%0d MemWrite=%b PCW=%b IRW=%b exp 0 0 0 0", state, MemWrite, PCWrite, IRWrite);
    end
    @(posedge clk); #1; rst = 1'b1; #1;
    n_tests++;
    if ({state, PCWrite, IRWrite} !== {4'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL post_reset_fetch state=%0d PCW=%b IRW=%b exp 0 1 1", state, PCWrite, IRWrite);
    end
    tick();
    n_tests++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL post_reset_decode state=%0d exp 1", state);
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_load_lb();
    test_store_sw();
    test_branch();
    test_jal();
    test_execi_lui();
    test_illegal();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter TRAP_ON_ILLEGAL, default 1: 1 = an unknown opcode parks the FSM in TRAP; 0 = treated as NOP, returns to FETCH.
REQ-002 SHALL have ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; asynchronous, active-low.
- op  in  7  opcode, instr[6:0].
- funct3  in  3  instr[14:12].
- funct7  in  1  instr[30].
- zero_flag  in  1  ALU result == 0.
- comp_flag  in  1  ALU result bit 0.
- PCWrite, AddrSrc, IRWrite, RegWrite, WDSrc, MemWrite  out  1 each  datapath strobes and selects.
- SrcA, SrcB, ResSrc, DataSrc  out  2 each  mux selects.
- ALUControll  out  4  ALU operation.
- ImmSrc  out  3  immediate type: I=0, S=1, B=2, J=3, U=4.
- memSize  out  2  access size, funct3[1:0].
- illegal  out  1  sticky illegal-opcode flag.
- state  out  4  current state, for debug.

Function
REQ-003 SHALL be a Moore FSM; all outputs decode from the current state, plus op/funct3/funct7/flags where stated.
REQ-004 SHALL use ALUControll encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
REQ-005 SHALL use these mux encodings:
- SrcA: 0 PC, 1 oldPC, 2 rs1 register, 3 zero.
- SrcB: 0 rs2 register, 1 imm, 2 constant 4.
- ResSrc: 0 registered ALU, 1 memory data, 2 ALU direct.
- AddrSrc: 0 PC, 1 result.
- WDSrc: 0 result, 1 PC.
REQ-006 SHALL drive every unlisted strobe to 0 and every unlisted select to 0 in each state.
REQ-007 FETCH SHALL drive AddrSrc=0, IRWrite=1, SrcA=0, SrcB=2, add, ResSrc=2, PCWrite=1; next state DECODE.
REQ-008 DECODE SHALL drive SrcA=1, SrcB=1, ImmSrc=B, add (precomputes branch target). It SHALL dispatch on op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 -> LUI
- 0010111 -> AUIPC
- other -> TRAP, or FETCH when TRAP_ON_ILLEGAL=0.
REQ-009 MEMADR SHALL drive SrcA=2, SrcB=1, add, ImmSrc=S for a store and I for a load; next MEMWRITE for a store, MEMREAD for a load.
REQ-010 MEMREAD SHALL drive AddrSrc=1, ResSrc=0, memSize=funct3[1:0]; next MEMWB.
REQ-011 MEMWB SHALL drive ResSrc=1, RegWrite=1, and DataSrc from funct3: lb -> 1, lh -> 2, lw/lbu/lhu -> 0; next FETCH.
REQ-012 MEMWRITE SHALL drive AddrSrc=1, ResSrc=0, MemWrite=1, memSize=funct3[1:0]; next FETCH.
REQ-013 EXECR SHALL drive SrcA=2, SrcB=0; EXECI SHALL drive SrcA=2, SrcB=1, ImmSrc=I; both next ALUWB.
REQ-014 ALU decode by funct3 SHALL be:
- 000: add; sub only when EXECR and funct7=1.
- 001: sll. 010: slt. 011: sltu. 100: xor.
- 101: srl, or sra when funct7=1 (EXECR and EXECI).
- 110: or. 111: and.
REQ-015 ALUWB SHALL drive ResSrc=0, RegWrite=1; next FETCH.
REQ-016 BRANCH SHALL drive SrcA=2, SrcB=0, ResSrc=0, with:
- beq/bne: sub; taken = zero_flag / !zero_flag.
- blt/bge: slt; taken = comp_flag / !comp_flag.
- bltu/bgeu: sltu; taken = comp_flag / !comp_flag.
- PCWrite = taken, combinationally in the same cycle.
- funct3 010/011: never taken.
- Next state FETCH.
REQ-017 JAL SHALL drive SrcA=1, SrcB=1, ImmSrc=J, add, ResSrc=2, PCWrite=1, RegWrite=1, WDSrc=1; next FETCH.
REQ-018 JALR SHALL be as JAL except SrcA=2 and ImmSrc=I.
REQ-019 LUI SHALL drive SrcA=3, SrcB=1, ImmSrc=U, add, ResSrc=2, RegWrite=1; AUIPC SHALL be identical except SrcA=1; both next FETCH.
REQ-020 TRAP SHALL drive all strobes 0, set illegal=1, and hold until reset.
REQ-021 Instruction latency SHALL be:
- 3 cycles: branch, jal, jalr, lui, auipc.
- 4 cycles: R, I-ALU, store.
- 5 cycles: load.

Reset
REQ-022 rst low SHALL asynchronously force state=FETCH and illegal=0.
REQ-023 While rst is low, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0 regardless of state.
REQ-024 Reset asserted mid-instruction SHALL abandon the instruction; the first FETCH strobes SHALL occur on the first rising clk after rst rises.

Verification
REQ-025 Reset release, then op=0110011, funct3=000, funct7=1 -> states FETCH, DECODE, EXECR (ALUControll=1), ALUWB (RegWrite=1), FETCH.
REQ-026 Load lb: op=0000011, funct3=000 -> MEMADR (ImmSrc=0), MEMREAD (AddrSrc=1), MEMWB (DataSrc=1, RegWrite=1); 5 cycles total.
REQ-027 bne, funct3=001:
- zero_flag=0 in BRANCH -> PCWrite=1, ResSrc=0.
- Repeat with zero_flag=1 -> PCWrite=0.
REQ-028 JAL: op=1101111 -> in JAL, PCWrite=RegWrite=WDSrc=1, SrcA=1, ImmSrc=3; returns to FETCH.
REQ-029 Illegal opcode op=1111111:
- TRAP_ON_ILLEGAL=1 -> illegal=1, strobes stay 0 for 10+ cycles.
- Reset clears illegal.
- TRAP_ON_ILLEGAL=0 -> DECODE goes straight to FETCH.
REQ-030 Assert rst low during MEMWRITE -> MemWrite drops to 0 immediately (asynchronously), state=FETCH.
